// File: rtl/mmio_bus_ctrl.sv
// Memory / memory-mapped IO steering with a request/response handshake and multi-cycle memory loads.
// Optional rising-edge input interrupts are built when IO_EDGE_IRQ_EN is defined.
module mmio_bus_ctrl #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'hFFFF_FC00),
  parameter int                CH_W    = 16,
  parameter int                NUM_OUT = 2,
  parameter int                NUM_IN  = 2,
  parameter int                MEM_LAT = 1,
  parameter logic [CH_W-1:0]   OUT_RST = '0
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    req_ready,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    addr_err,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic [NUM_IN*CH_W-1:0]  io_in,
  output logic [NUM_OUT*CH_W-1:0] io_out
`ifdef IO_EDGE_IRQ_EN
  ,
  output logic                    irq
`endif
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, MEM_RD, RESP} state_t;

  state_t                  state, state_nx;
  logic                    accept, is_io, io_err, rd_ok, wr_ok;
  logic [ADDR_W-1:0]       w;
  logic [DATA_W-1:0]       io_rdata;
  logic [CNT_W-1:0]        cnt;
  logic                    err_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [NUM_IN*CH_W-1:0]  sync1, sync2;
`ifdef IO_EDGE_IRQ_EN
  logic [NUM_IN*CH_W-1:0]  sync3, pending, clr_mask;
`endif

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign is_io     = (req_addr >= IO_BASE);
  assign w         = (req_addr - IO_BASE) >> 2;

  always_comb begin
    io_rdata = '0;
    rd_ok    = 1'b0;
    wr_ok    = 1'b0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      if (w == ADDR_W'(k)) begin
        io_rdata = DATA_W'(io_out[k*CH_W +: CH_W]);
        rd_ok    = 1'b1;
        wr_ok    = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (w == ADDR_W'(NUM_OUT + k)) begin
        io_rdata = DATA_W'(sync2[k*CH_W +: CH_W]);
        rd_ok    = 1'b1;
      end
    end
`ifdef IO_EDGE_IRQ_EN
    clr_mask = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (w == ADDR_W'(NUM_OUT + NUM_IN + k)) begin
        io_rdata = DATA_W'(pending[k*CH_W +: CH_W]);
        rd_ok    = 1'b1;
        wr_ok    = 1'b1;
        if (accept && is_io && req_write)
          clr_mask[k*CH_W +: CH_W] = req_wdata[CH_W-1:0];
      end
    end
`endif
  end

  assign io_err = is_io & (req_write ? ~wr_ok : ~rd_ok);

  // Memory strobes are combinational from the request; the registered copy keeps the bus stable afterwards.
  assign mem_en    = accept & ~is_io;
  assign mem_we    = mem_en & req_write;
  assign mem_addr  = mem_en ? req_addr  : addr_q;
  assign mem_wdata = mem_en ? req_wdata : wdata_q;

  assign rsp_valid = (state == RESP);
  assign addr_err  = (state == RESP) & err_q;

  always_ff @(posedge clock) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (is_io || req_write) ? RESP : MEM_RD;
      MEM_RD:  if (cnt == '0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      rsp_rdata <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      io_out    <= {NUM_OUT{OUT_RST}};
      sync1     <= '0;
      sync2     <= '0;
`ifdef IO_EDGE_IRQ_EN
      sync3     <= '0;
      pending   <= '0;
      irq       <= 1'b0;
`endif
    end else begin
      sync1 <= io_in;
      sync2 <= sync1;
`ifdef IO_EDGE_IRQ_EN
      sync3   <= sync2;
      // New edges are OR-ed in after the clear so a same-cycle set wins.
      pending <= (pending & ~clr_mask) | (sync2 & ~sync3);
      irq     <= |pending;
`endif
      if (accept) begin
        err_q <= io_err;
        if (is_io && !req_write) rsp_rdata <= io_rdata;
        if (!is_io) begin
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          if (!req_write) cnt <= CNT_W'(MEM_LAT - 1);
        end
        if (is_io && req_write) begin
          for (int unsigned k = 0; k < NUM_OUT; k++) begin
            if (w == ADDR_W'(k)) io_out[k*CH_W +: CH_W] <= req_wdata[CH_W-1:0];
          end
        end
      end
      if (state == MEM_RD) begin
        if (cnt == '0) rsp_rdata <= mem_rdata;
        else           cnt       <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Self-checking bench for mmio_bus_ctrl (MEM_LAT = 3): directed steps plus randomized accesses
// checked against a word-level model of the memory/IO map.
module tb_mmio_bus_ctrl;

  localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;
  localparam int          MEM_LAT = 3;

  logic        clock = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, addr_err, mem_en, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] io_in, io_out;
`ifdef IO_EDGE_IRQ_EN
  logic        irq;
`endif

  int checks   = 0;
  int failures = 0;

  logic [15:0] out_m [2];
  logic [31:0] rdata_m;

  always #5 clock = ~clock;

  mmio_bus_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clock(clock), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .addr_err(addr_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .io_in(io_in), .io_out(io_out)
`ifdef IO_EDGE_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] v);
    @(negedge clock);
    io_in = v;
    repeat (3) @(negedge clock);
  endtask

  // One complete access: expectations come from the address map, then the DUT is driven and compared.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] md);
    logic        io, err;
    logic [31:0] off, exp_rd;
    int unsigned w;
    int          lat, exp_lat;
    io     = (addr >= IO_BASE);
    off    = addr - IO_BASE;
    w      = off / 4;
    err    = 1'b0;
    exp_rd = rdata_m;
    if (io) begin
      exp_lat = 1;
      if (w < 2) begin
        if (wr) out_m[w] = wd[15:0];
        else    exp_rd = {16'h0, out_m[w]};
      end else if (w < 4) begin
        if (wr) err = 1'b1;
        else    exp_rd = {16'h0, io_in[(w-2)*16 +: 16]};
      end else begin
        err = 1'b1;
        if (!wr) exp_rd = '0;
      end
    end else begin
      exp_lat = wr ? 1 : MEM_LAT + 1;
      if (!wr) exp_rd = md;
    end
    rdata_m = exp_rd;

    @(negedge clock);
    check("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    #1;
    check("mem_en", mem_en, !io);
    check("mem_we", mem_we, !io && wr);
    if (!io) begin
      check("mem_addr", mem_addr, addr);
      if (wr) check("mem_wdata", mem_wdata, wd);
    end
    @(negedge clock);
    // a competing request held during the wait must be ignored
    req_write = 1'b1; req_addr = 32'h0000_0100; req_wdata = 32'hBAD0_BAD0;
    lat = 1;
    mem_rdata = (lat == MEM_LAT) ? md : $urandom;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      check("busy_ready", req_ready, 0);
      check("busy_mem_en", mem_en, 0);
      @(negedge clock);
      lat++;
      mem_rdata = (lat == MEM_LAT) ? md : $urandom;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_valid", rsp_valid, 1);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("addr_err", addr_err, err);
    check("ready_resp", req_ready, 0);
    check("io_out", io_out, {out_m[1], out_m[0]});
    req_valid = 1'b0;
    @(negedge clock);
    check("rsp_pulse", rsp_valid, 0);
    check("err_pulse", addr_err, 0);
    check("ready_back", req_ready, 1);
    check("rdata_hold", rsp_rdata, exp_rd);
  endtask

  initial begin
    logic [31:0] a, d;
    int unsigned kind;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0; io_in = '0;
    out_m[0] = '0; out_m[1] = '0; rdata_m = '0;

    // reset then idle
    repeat (2) @(negedge clock);
    check("rst_io_out", io_out, 32'h0);
    check("rst_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_addr_err", addr_err, 0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("idle_mem_en", mem_en, 0);
      check("idle_rsp_valid", rsp_valid, 0);
    end

    // directed steps
    access(1'b1, IO_BASE, 32'h0000_A5A5, '0);
    set_in(32'h1234_0000);
    access(1'b0, IO_BASE + 32'hC, '0, '0);
    access(1'b0, 32'h0000_0200, '0, 32'hDEAD_BEEF);
    access(1'b1, IO_BASE + 32'h8, 32'h0000_FFFF, '0);
    access(1'b0, IO_BASE + 32'h40, '0, '0);
    access(1'b1, IO_BASE + 32'h4, 32'hFFFF_5A5A, '0);
    access(1'b0, IO_BASE + 32'h4, '0, '0);
    access(1'b1, 32'h0000_0300, 32'h0BAD_F00D, '0);
    access(1'b0, IO_BASE + 32'h10, '0, '0);

    // reset during MEM_RD abandons the load
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    check("midload_busy", req_ready, 0);
    rst = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    out_m[0] = '0; out_m[1] = '0; rdata_m = '0;
    check("midload_rsp_in_rst", rsp_valid, 0);
    @(negedge clock);
    check("midload_ready", req_ready, 1);
    check("midload_io_out", io_out, 32'h0);
    check("midload_rdata", rsp_rdata, 0);
    repeat (5) begin
      check("midload_no_rsp", rsp_valid, 0);
      @(negedge clock);
    end

    // randomized accesses against the model
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 5);
      d    = $urandom;
      case (kind)
        0: begin a = $urandom & 32'hFFFF_FBFC; access(1'b0, a, $urandom, d); end
        1: begin a = $urandom & 32'hFFFF_FBFC; access(1'b1, a, d, '0); end
        2, 3: begin
          a = IO_BASE + 4 * $urandom_range(0, 5);
          access(1'($urandom_range(0, 1)), a, d, '0);
        end
        4: begin
          a = IO_BASE + 4 * $urandom_range(6, 255);
          access(1'($urandom_range(0, 1)), a, d, '0);
        end
        default: set_in(d);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
- Parametrised successor to the single-cycle memory/IO steering logic; sits between the CPU execute/writeback stage and data memory plus board IO (switches, LEDs).
- Decodes each load/store to data memory or memory-mapped IO and supports multi-cycle memory latency through a request/response handshake.
- Holds N registered output channels and samples M synchronised input channels.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 32, address width.
- IO_BASE, 32'hFFFF_FC00, lowest IO address; any address >= IO_BASE is IO.
- CH_W, 16, width of each IO channel (CH_W <= DATA_W).
- NUM_OUT, 2, number of output channels (LED banks).
- NUM_IN, 2, number of input channels (switch banks).
- MEM_LAT, 1, data-memory read latency in cycles (>= 1).
- OUT_RST, 0, reset value of every output channel.

Ports:
- clock  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  1  CPU access request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address, word aligned.
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  load data, valid with rsp_valid.
- addr_err  out  1  one-cycle pulse with rsp_valid on an illegal IO access.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- io_in  in  NUM_IN*CH_W  raw input channels (channel k at [k*CH_W +: CH_W]).
- io_out  out  NUM_OUT*CH_W  registered output channels.
- irq  out  1  edge interrupt; present only with IO_EDGE_IRQ_EN.

Behaviour:
- Reset (rst == 0 at a clock edge):
  - State goes to IDLE; req_ready = 1 after reset.
  - rsp_valid, addr_err, mem_en and mem_we are 0; rsp_rdata is 0.
  - io_out is OUT_RST in every channel; synchroniser flops are 0.
  - Any in-flight memory access is abandoned and no response is produced.
- IO map: word index w = (req_addr - IO_BASE) >> 2.
  - w in 0..NUM_OUT-1: output channel w, read/write.
  - w in NUM_OUT..NUM_OUT+NUM_IN-1: input channel w-NUM_OUT, read-only.
  - Any other w is illegal.
- io_in passes through a 2-flop synchroniser per bit. Reads return the synchronised value, zero-extended to DATA_W.
- FSM states: IDLE, MEM_RD, RESP.
- IDLE, request accepted:
  - IO load or store: complete internally; go to RESP.
  - IO store to an output channel: io_out[w] <= req_wdata[CH_W-1:0], visible the cycle after acceptance.
  - IO store to an input channel or illegal w: no register changes; addr_err is set with the response.
  - IO load from illegal w: returns 0 with addr_err.
  - Memory store: mem_en = mem_we = 1 for the acceptance cycle only, combinationally driven from the request; go to RESP.
  - Memory load: mem_en = 1, mem_we = 0 in the acceptance cycle; go to MEM_RD with a wait counter = MEM_LAT-1.
- MEM_RD: decrement the counter each cycle. In the cycle the counter is 0, capture mem_rdata into rsp_rdata and go to RESP.
- RESP: rsp_valid = 1 for exactly one cycle; go to IDLE; req_ready returns to 1 the following cycle.
- Latency from acceptance to rsp_valid:
  - IO access and memory store: 1 cycle.
  - Memory load: MEM_LAT + 1 cycles.
- No response backpressure. req_valid while req_ready = 0 is ignored, and the requester must hold the request.
- rsp_rdata holds its value until the next load response; stores leave it unchanged.
- mem_addr and mem_wdata follow req_addr and req_wdata in the acceptance cycle. Outside that cycle their value is don't-care but must be stable (registered copy).

Optional Feature:
- Macro IO_EDGE_IRQ_EN.
- When defined:
  - Rising-edge detect on each synchronised input bit sets a sticky bit in a pending register of NUM_IN*CH_W bits.
  - Pending is readable at word index NUM_OUT+NUM_IN+k for channel k.
  - A store to that index clears the bits written as 1 (write-1-to-clear). If a set and a clear hit the same bit in the same cycle, the set wins.
  - irq = OR of all pending bits, registered.
  - Pending resets to 0.
- When undefined:
  - There is no pending logic and no irq port.
  - Those word indices are illegal and raise addr_err.

Test Plan:
- Reset then idle: rst = 0 for 2 cycles, then release -> io_out = OUT_RST, req_ready = 1, rsp_valid = 0; no mem_en seen.
- IO store: store 32'h0000_A5A5 to IO_BASE+0 -> rsp_valid 1 cycle after acceptance; io_out[15:0] = 16'hA5A5 on the same cycle; mem_en stays 0.
- Switch read: io_in[31:16] = 16'h1234, then load IO_BASE+0xC (NUM_OUT = 2) -> rsp_rdata = 32'h0000_1234, addr_err = 0.
- Memory load, MEM_LAT = 3: mem_rdata = 32'hDEAD_BEEF after acceptance -> req_ready = 0 for 4 cycles; rsp_valid 4 cycles after acceptance with rsp_rdata = 32'hDEAD_BEEF; a second req_valid during the wait is not accepted.
- Illegal IO: store to IO_BASE+0x8 (input channel 0) -> addr_err and rsp_valid together, io_out unchanged. Load from IO_BASE+0x40 -> rsp_rdata = 0, addr_err = 1.
- Reset mid-load: rst = 0 during MEM_RD -> no rsp_valid ever produced for that access; FSM in IDLE and req_ready = 1 the cycle after rst is released.
